// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state encoding,
// and the legality/alignment helpers used at issue time.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WB} lsu_state_t;

  // Unsigned widths only exist for loads.
  function automatic logic f3_legal(input logic st, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !st;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic ea_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return !lo[0];
      F3_W:        return (lo == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replicated data and load lane extraction.
// Latency: combinational. Backpressure: none.
// Only the low two address bits matter; the memory side is word addressed.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (ea_lo)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = ea_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    wstrb    = 4'b1111;
    wdata    = store_data;
    load_val = mem_rdata;
    case (funct3)
      F3_B: begin
        wstrb    = 4'b0001 << ea_lo;
        wdata    = {4{store_data[7:0]}};
        load_val = {{24{lane_b[7]}}, lane_b};
      end
      F3_H: begin
        wstrb    = 4'b0011 << ea_lo;
        wdata    = {2{store_data[15:0]}};
        load_val = {{16{lane_h[15]}}, lane_h};
      end
      F3_BU:   load_val = {24'h0, lane_b};
      F3_HU:   load_val = {16'h0, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store stage: issue -> memory req/ack -> one-cycle register writeback.
// Latency: load with ack one cycle after issue writes back two cycles after issue; stores finish on ack.
// Backpressure: start is ignored while busy; LSU_TIMEOUT_EN bounds the ack wait to TIMEOUT_CYCLES.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  write,
  output logic [31:0] write_data,
  output logic        RegWrite
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  lsu_state_t  state;
  logic [2:0]  f3_q;
  logic [1:0]  ea_lo_q;
  logic [4:0]  rd_q;
  logic [31:0] ea;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
`endif

  assign ea   = base + offset;
  assign busy = (state != IDLE);

  // One aligner serves both directions: issue-time operands in IDLE, captured ones afterwards.
  assign al_f3 = (state == IDLE) ? funct3   : f3_q;
  assign al_lo = (state == IDLE) ? ea[1:0]  : ea_lo_q;

  lsu_align u_align (
    .funct3     (al_f3),
    .ea_lo      (al_lo),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_val   (al_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      f3_q       <= 3'b0;
      ea_lo_q    <= 2'b0;
      rd_q       <= 5'b0;
      fault      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'b0;
      write      <= 5'b0;
      write_data <= 32'h0;
      RegWrite   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt   <= 8'h0;
`endif
    end else begin
      fault    <= 1'b0;
      RegWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!f3_legal(is_store, funct3) || !ea_aligned(funct3, ea[1:0])) begin
              fault <= 1'b1;
            end else begin
              f3_q      <= funct3;
              ea_lo_q   <= ea[1:0];
              rd_q      <= rd;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {ea[31:2], 2'b00};
              mem_wdata <= is_store ? al_wdata : 32'h0;
              mem_wstrb <= is_store ? al_wstrb : 4'b0000;
              state     <= REQ;
`ifdef LSU_TIMEOUT_EN
              wait_cnt  <= 8'h0;
`endif
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            if (mem_we) begin
              state <= IDLE;
            end else begin
              write      <= rd_q;
              write_data <= al_load;
              RegWrite   <= (rd_q != 5'd0);
              state      <= WB;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            fault     <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (default build, no timeout).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        busy;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [4:0]  write;
  logic [31:0] write_data;
  logic        RegWrite;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .base       (base),
    .offset     (offset),
    .store_data (store_data),
    .rd         (rd),
    .busy       (busy),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .write      (write),
    .write_data (write_data),
    .RegWrite   (RegWrite)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns in the first cycle after issue.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] b,
                       input logic [31:0] o, input logic [31:0] sd, input logic [4:0] r);
    is_store = st; funct3 = f3; base = b; offset = o; store_data = sd; rd = r;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b0; base = 32'h0;
    offset = 32'h0; store_data = 32'h0; rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    checks++;
    if ({busy, fault, mem_req, mem_we, RegWrite} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got %b expected 00000", {busy, fault, mem_req, mem_we, RegWrite});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb, write, write_data} !== 105'h0) begin
      failures++; $display("FAIL reset_data got addr=%h wdata=%h wstrb=%b write=%0d wd=%h expected all zero",
                           mem_addr, mem_wdata, mem_wstrb, write, write_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_loads();
    issue(1'b0, 3'b000, 32'h100, 32'd3, 32'h0, 5'd5);
    checks++;
    if ({mem_req, mem_we, busy, mem_addr, mem_wstrb} !== {3'b101, 32'h100, 4'b0000}) begin
      failures++; $display("FAIL lb_req got req=%b we=%b busy=%b addr=%h wstrb=%b expected 1 0 1 00000100 0000",
                           mem_req, mem_we, busy, mem_addr, mem_wstrb);
    end
    mem_rdata = 32'h80AABBCC; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({RegWrite, write, write_data} !== {1'b1, 5'd5, 32'hFFFFFF80}) begin
      failures++; $display("FAIL lb_wb got rw=%b rd=%0d data=%h expected 1 5 ffffff80", RegWrite, write, write_data);
    end
    tick();
    checks++;
    if ({RegWrite, busy, write_data} !== {2'b00, 32'hFFFFFF80}) begin
      failures++; $display("FAIL lb_after got rw=%b busy=%b data=%h expected 0 0 ffffff80", RegWrite, busy, write_data);
    end
    issue(1'b0, 3'b100, 32'h100, 32'd3, 32'h0, 5'd5);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({RegWrite, write_data} !== {1'b1, 32'h00000080}) begin
      failures++; $display("FAIL lbu_wb got rw=%b data=%h expected 1 00000080", RegWrite, write_data);
    end
    tick();
    issue(1'b0, 3'b101, 32'h100, 32'd2, 32'h0, 5'd6);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({RegWrite, write, write_data} !== {1'b1, 5'd6, 32'h000080AA}) begin
      failures++; $display("FAIL lhu_wb got rw=%b rd=%0d data=%h expected 1 6 000080aa", RegWrite, write, write_data);
    end
    tick();
  endtask

  task automatic test_stores();
    issue(1'b1, 3'b001, 32'h200, 32'd2, 32'h1234ABCD, 5'd7);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== {2'b11, 32'h200, 4'b1100, 32'hABCDABCD}) begin
      failures++; $display("FAIL sh_req got req=%b we=%b addr=%h wstrb=%b wdata=%h expected 1 1 00000200 1100 abcdabcd",
                           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, busy, RegWrite, fault} !== 4'b0000) begin
      failures++; $display("FAIL sh_done got req=%b busy=%b rw=%b fault=%b expected 0000", mem_req, busy, RegWrite, fault);
    end
    issue(1'b1, 3'b000, 32'h500, 32'd1, 32'h0000775A, 5'd0);
    checks++;
    if ({mem_addr, mem_wstrb, mem_wdata} !== {32'h500, 4'b0010, 32'h5A5A5A5A}) begin
      failures++; $display("FAIL sb_req got addr=%h wstrb=%b wdata=%h expected 00000500 0010 5a5a5a5a",
                           mem_addr, mem_wstrb, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_faults();
    issue(1'b0, 3'b010, 32'h100, 32'd2, 32'h0, 5'd3);
    checks++;
    if ({fault, mem_req, busy} !== 3'b100) begin
      failures++; $display("FAIL lw_misaligned got fault=%b req=%b busy=%b expected 1 0 0", fault, mem_req, busy);
    end
    tick();
    checks++;
    if ({fault, mem_req, busy} !== 3'b000) begin
      failures++; $display("FAIL fault_pulse got fault=%b req=%b busy=%b expected 0 0 0", fault, mem_req, busy);
    end
    issue(1'b0, 3'b011, 32'h100, 32'd0, 32'h0, 5'd3);
    checks++;
    if ({fault, mem_req, busy} !== 3'b100) begin
      failures++; $display("FAIL illegal_f3 got fault=%b req=%b busy=%b expected 1 0 0", fault, mem_req, busy);
    end
    issue(1'b1, 3'b100, 32'h100, 32'd0, 32'h0, 5'd3);
    checks++;
    if ({fault, mem_req, busy} !== 3'b100) begin
      failures++; $display("FAIL store_unsigned got fault=%b req=%b busy=%b expected 1 0 0", fault, mem_req, busy);
    end
    tick();
  endtask

  task automatic test_ack_wait();
    issue(1'b0, 3'b001, 32'h300, 32'd2, 32'h0, 5'd0);
    mem_rdata = 32'h80011234;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mem_req, mem_we, busy, mem_addr, mem_wstrb} !== {3'b101, 32'h300, 4'b0000}) begin
        failures++; $display("FAIL wait_stable[%0d] got req=%b we=%b busy=%b addr=%h wstrb=%b expected 1 0 1 00000300 0000",
                             i, mem_req, mem_we, busy, mem_addr, mem_wstrb);
      end
      is_store = 1'b1; funct3 = 3'b010; base = 32'h900 + 32'(i * 4); offset = 32'h0; rd = 5'd9;
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({RegWrite, busy, fault} !== 3'b010) begin
      failures++; $display("FAIL rd0_wb got rw=%b busy=%b fault=%b expected 0 1 0", RegWrite, busy, fault);
    end
    tick();
    checks++;
    if ({RegWrite, busy, mem_req} !== 3'b000) begin
      failures++; $display("FAIL rd0_after got rw=%b busy=%b req=%b expected 0 0 0", RegWrite, busy, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 3'b010, 32'h40, 32'd0, 32'hDEADBEEF, 5'd1);
    checks++;
    if ({mem_wstrb, mem_wdata} !== {4'b1111, 32'hDEADBEEF}) begin
      failures++; $display("FAIL sw_req got wstrb=%b wdata=%h expected 1111 deadbeef", mem_wstrb, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    issue(1'b0, 3'b010, 32'h40, 32'd4, 32'h0, 5'd31);
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h44}) begin
      failures++; $display("FAIL b2b_lw_req got req=%b we=%b addr=%h expected 1 0 00000044", mem_req, mem_we, mem_addr);
    end
    mem_rdata = 32'h11223344; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({RegWrite, write, write_data} !== {1'b1, 5'd31, 32'h11223344}) begin
      failures++; $display("FAIL b2b_lw_wb got rw=%b rd=%0d data=%h expected 1 31 11223344", RegWrite, write, write_data);
    end
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({RegWrite, busy, mem_req, fault} !== 4'b0000) begin
      failures++; $display("FAIL idle_ack got rw=%b busy=%b req=%b fault=%b expected 0000", RegWrite, busy, mem_req, fault);
    end
  endtask

  task automatic test_wrap_and_abort();
    issue(1'b0, 3'b010, 32'hFFFFFFFC, 32'd8, 32'h0, 5'd9);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h4}) begin
      failures++; $display("FAIL ea_wrap got req=%b addr=%h expected 1 00000004", mem_req, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, fault, RegWrite} !== 4'b0000) begin
      failures++; $display("FAIL async_abort got req=%b busy=%b fault=%b rw=%b expected 0000", mem_req, busy, fault, RegWrite);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({mem_req, busy, fault, RegWrite} !== 4'b0000) begin
      failures++; $display("FAIL post_abort got req=%b busy=%b fault=%b rw=%b expected 0000", mem_req, busy, fault, RegWrite);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_ack_wait();
    test_back_to_back();
    test_wrap_and_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle RV32I load/store execution stage, sitting directly upstream of the register file write port.
- Computes the effective address and performs a req/ack transaction with data memory.
- Byte-aligns and sign- or zero-extends load data, then drives a one-cycle register-file write (write, write_data, RegWrite).
- Stores complete without any register-file write.

Parameters:
- TIMEOUT_CYCLES, 16, ack wait limit in cycles (used only when LSU_TIMEOUT_EN is defined); legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  issue request; accepted only when busy=0
- is_store  in  1  1=store (SB/SH/SW), 0=load
- funct3  in  3  RV32I width/sign code
- base  in  32  rs1 value
- offset  in  32  sign-extended immediate
- store_data  in  32  rs2 value
- rd  in  5  load destination register
- busy  out  1  FSM not in IDLE
- fault  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout
- mem_req  out  1  memory request
- mem_we  out  1  1=write
- mem_addr  out  32  word address, bits [1:0] forced to 0
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte enables; 0000 for loads
- mem_ack  in  1  memory completion, sampled at rising edge
- mem_rdata  in  32  read word, valid with mem_ack
- write  out  5  register-file destination
- write_data  out  32  register-file data
- RegWrite  out  1  register-file write enable

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset asserted mid-transaction aborts it immediately: mem_req and RegWrite drop asynchronously, and no fault is raised.
- FSM states: IDLE, REQ, WB.
- IDLE, start=1 in cycle T:
  - ea = base + offset, modulo 2^32, carry dropped.
  - Legality: loads allow funct3 000/001/010/100/101; stores allow 000/001/010.
  - Alignment: halfword requires ea[0]=0; word requires ea[1:0]=0.
  - Illegal or misaligned: fault=1 in T+1, FSM stays in IDLE, no memory access.
  - Otherwise: register ea, funct3, rd and lane-shifted data; go to REQ. mem_req=1 from T+1.
- REQ:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb held stable until the cycle mem_ack=1.
  - Store wstrb: SB = 0001 << ea[1:0]; SH = 0011 << ea[1:0]; SW = 1111.
  - Store wdata: SB replicates byte ×4; SH replicates half ×2; SW passes data through.
  - On ack, store: go to IDLE, mem_req=0 next cycle.
  - On ack, load: capture the selected lane (LB/LH sign-extend, LBU/LHU zero-extend, LW raw) and go to WB.
  - An ack arriving while mem_req=0 is ignored.
- WB:
  - Exactly one cycle: RegWrite=1, write=rd, write_data=extended value; then go to IDLE.
  - If rd=0, RegWrite stays 0 while WB is still occupied for one cycle.
  - Outside WB, RegWrite=0; write and write_data hold their last values.
- Latency: load with ack at T+1 gives RegWrite at T+2; minimum store turnaround is 2 cycles.
- busy=1 in REQ and WB. start while busy=1 is ignored, with no queuing and no fault.
- Next start accepted in the cycle busy returns to 0.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - At count = TIMEOUT_CYCLES-1 with no ack: drop mem_req, pulse fault, return to IDLE, no register write.
  - An ack in the same cycle as expiry wins.
- Undefined: no counter; REQ waits for ack indefinitely.

Decomposition:
- Shared package rv32i_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - LSU state enum {IDLE, REQ, WB}.
- One natural sub-module, lsu_align: purely combinational. It generates wstrb and wdata from (funct3, ea[1:0], store_data) and extracts the load value from (funct3, ea[1:0], mem_rdata).

Test Plan:
- LB base=0x100, offset=3, mem_rdata=0x80AABBCC, rd=5 -> mem_addr=0x100, wstrb=0000, RegWrite pulse with write=5, write_data=0xFFFFFF80; LBU in the same setup -> 0x00000080.
- SH base=0x200, offset=2, store_data=0x1234ABCD -> mem_we=1, mem_addr=0x200, wstrb=1100, wdata=0xABCDABCD; no RegWrite.
- LW ea=0x102 -> fault pulse at T+1, mem_req never asserted, busy stays 0; funct3=011 load -> fault likewise.
- Ack withheld 5 cycles on LH: mem_req, mem_addr and mem_wstrb stable all 5 cycles; start pulses during REQ ignored; rd=0 -> no RegWrite, busy drops after WB.
- base=0xFFFFFFFC, offset=8 -> ea wraps to 0x4; rst_n low during REQ -> mem_req=0 immediately, state IDLE, no fault.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> fault on the 4th REQ cycle, then IDLE; ack on the 4th REQ cycle -> normal completion, no fault.
